// File: rtl/pragmatic_term_scheduler.sv
// Term scheduler for the 16-lane Pragmatic bit-serial MAC: splits each weight into its set bits
// and issues one term per lane per cycle as 1st-stage offset controls plus a shared base shift.
module pragmatic_term_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LENGTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_in,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_first,
  output logic                                  out_last,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_out,
  output logic [VEC_LENGTH-1:0][1:0]            shift_1st_sel,
  output logic [VEC_LENGTH-1:0]                 shift_1st_en,
  output logic [VEC_LENGTH-1:0]                 is_neg,
  output logic [2:0]                            shift_2nd_sel,
  output logic                                  shift_2nd_en
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [DATA_WIDTH-1:0] WinMask = DATA_WIDTH'(4'hF);

  state_e                                r_state, w_state_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_mask, w_mask_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_act, w_act_d;
  logic [VEC_LENGTH-1:0]                 r_neg, w_neg_d;
  logic                                  r_first, w_first_d;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_mag;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_winbits;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_emit;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_mask_left;
  logic [VEC_LENGTH-1:0][3:0]            w_win;
  logic [VEC_LENGTH-1:0][1:0]            w_sel;
  logic [VEC_LENGTH-1:0]                 w_en;
  logic [DATA_WIDTH-1:0]                 w_union;
  logic [2:0]                            w_base;
  logic                                  w_run, w_last, w_adv, w_accept;

  // Base is the lowest set bit over every lane, so all bits at base are emitted this cycle.
  always_comb begin
    w_union = '0;
    for (int unsigned j = 0; j < VEC_LENGTH; j++) begin
      w_union = w_union | r_mask[j];
    end
    w_base = '0;
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      if (w_union[i]) w_base = 3'(i);
    end
  end

  // Per lane: lowest set bit inside the 4-bit window starting at base.
  always_comb begin
    for (int unsigned j = 0; j < VEC_LENGTH; j++) begin
      w_win[j]       = 4'(r_mask[j] >> w_base);
      w_en[j]        = |w_win[j];
      w_sel[j]       = '0;
      for (int k = 3; k >= 0; k--) begin
        if (w_win[j][k]) w_sel[j] = 2'(k);
      end
      w_winbits[j]   = r_mask[j] & (WinMask << w_base);
      w_emit[j]      = w_winbits[j] & (~w_winbits[j] + 1'b1);
      w_mask_left[j] = r_mask[j] & ~w_emit[j];
      w_mag[j]       = weight_in[j][DATA_WIDTH-1] ? (~weight_in[j] + 1'b1) : weight_in[j];
    end
  end

  assign w_run    = (r_state == StRun);
  assign w_last   = ~|w_mask_left;
  assign w_adv    = w_run & out_ready;
  assign in_ready = reset & (~w_run | (w_adv & w_last));
  assign w_accept = in_valid & in_ready;

  always_comb begin
    out_valid     = w_run;
    out_first     = w_run & r_first;
    out_last      = w_run & w_last;
    shift_1st_en  = w_run ? w_en : '0;
    shift_1st_sel = w_run ? w_sel : '0;
    shift_2nd_sel = w_run ? w_base : '0;
    shift_2nd_en  = w_run & (|w_en);
    act_out       = r_act;
    is_neg        = r_neg;
  end

  always_comb begin
    w_state_d = r_state;
    w_mask_d  = r_mask;
    w_act_d   = r_act;
    w_neg_d   = r_neg;
    w_first_d = r_first;
    if (w_adv) begin
      w_mask_d  = w_mask_left;
      w_first_d = 1'b0;
      if (w_last) w_state_d = StIdle;
    end
    if (w_accept) begin
      w_mask_d  = w_mag;
      w_act_d   = act_in;
      w_first_d = 1'b1;
      w_state_d = StRun;
      for (int unsigned j = 0; j < VEC_LENGTH; j++) begin
        w_neg_d[j] = weight_in[j][DATA_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_mask  <= '0;
      r_act   <= '0;
      r_neg   <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_mask  <= w_mask_d;
      r_act   <= w_act_d;
      r_neg   <= w_neg_d;
      r_first <= w_first_d;
    end
  end

endmodule

// File: tb/tb_pragmatic_term_scheduler.sv
// Scoreboard bench for pragmatic_term_scheduler: directed groups with hand-computed terms plus
// random groups checked by dot-product reconstruction.
module tb_pragmatic_term_scheduler;

  typedef logic [15:0][7:0] vec_t;

  typedef struct {
    logic              first;
    logic              last;
    logic [15:0]       en;
    logic [15:0][1:0]  sel;
    logic [2:0]        base;
    logic              sen;
  } term_t;

  typedef struct {
    int          dot;
    bit          chk;
    logic [15:0] neg;
    vec_t        act;
  } group_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  vec_t             weight_in, act_in, act_out;
  logic             out_valid, out_ready, out_first, out_last;
  logic [15:0][1:0] shift_1st_sel;
  logic [15:0]      shift_1st_en, is_neg;
  logic [2:0]       shift_2nd_sel;
  logic             shift_2nd_en;

  term_t  tq[$];
  group_t gq[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     acc = 0;
  int     ncyc = 0;
  int     idle_run = 0;
  int     last_gap = -1;
  bit     rdy_auto = 1'b1;
  bit     rdy_rand = 1'b0;

  pragmatic_term_scheduler #(.DATA_WIDTH(8), .VEC_LENGTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .weight_in    (weight_in),
    .act_in       (act_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_first    (out_first),
    .out_last     (out_last),
    .act_out      (act_out),
    .shift_1st_sel(shift_1st_sel),
    .shift_1st_en (shift_1st_en),
    .is_neg       (is_neg),
    .shift_2nd_sel(shift_2nd_sel),
    .shift_2nd_en (shift_2nd_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic push_term(input bit f, input bit l, input logic [15:0] en,
                           input logic [31:0] sel, input logic [2:0] b, input bit s);
    term_t t;
    t.first = f; t.last = l; t.en = en; t.sel = sel; t.base = b; t.sen = s;
    tq.push_back(t);
  endtask

  function automatic int dotp(input vec_t w, input vec_t a);
    int s = 0;
    for (int j = 0; j < 16; j++) s += int'($signed(w[j])) * int'($signed(a[j]));
    return s;
  endfunction

  // Called with the next posedge ahead; returns just after the accepting posedge.
  task automatic send(input vec_t w, input vec_t a, input bit chk_terms);
    group_t g;
    int t = 0;
    in_valid = 1'b1; weight_in = w; act_in = a;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    g.dot = dotp(w, a); g.chk = chk_terms; g.act = a;
    for (int j = 0; j < 16; j++) g.neg[j] = w[j][7];
    gq.push_back(g);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (gq.size() != 0 && t < budget) begin
      @(posedge clk);
      #1 t++;
    end
    check("drain", 128'(gq.size()), 128'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 if (rdy_auto) out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every presented term (stalled or consumed) against the queue heads.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (!out_valid) idle_run++;
      else if (gq.size() == 0) check("orphan_term", 1'b1, 1'b0);
      else begin
        group_t g;
        g = gq[0];
        if (out_first && ncyc == 0) last_gap = idle_run;
        idle_run = 0;
        check("act_out", act_out, g.act);
        check("is_neg", is_neg, g.neg);
        if (g.chk) begin
          if (tq.size() == 0) check("unexpected_term", 1'b1, 1'b0);
          else begin
            check("first", out_first, tq[0].first);
            check("last", out_last, tq[0].last);
            check("en1", shift_1st_en, tq[0].en);
            check("sel1", shift_1st_sel, tq[0].sel);
            check("sel2", shift_2nd_sel, tq[0].base);
            check("en2", shift_2nd_en, tq[0].sen);
          end
        end
        check("in_ready", in_ready, out_ready && out_last);
        if (out_ready) begin
          for (int j = 0; j < 16; j++) begin
            if (shift_1st_en[j]) begin
              int t;
              t = int'($signed(act_out[j])) * (1 << (int'(shift_1st_sel[j]) + int'(shift_2nd_sel)));
              acc += is_neg[j] ? -t : t;
            end
          end
          ncyc++;
          if (g.chk && tq.size() != 0) void'(tq.pop_front());
          if (out_last) begin
            check("dot", 128'(acc), 128'(g.dot));
            check("cycles_le8", ncyc <= 8, 1'b1);
            void'(gq.pop_front());
            acc = 0;
            ncyc = 0;
          end
        end
      end
    end
  end

  initial begin
    vec_t w, a, w2;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; weight_in = '0; act_in = '0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_act_out", act_out, '0);
    check("rst_is_neg", is_neg, '0);
    check("rst_en2", shift_2nd_en, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);

    for (int j = 0; j < 16; j++) a[j] = 8'(j * 7 - 50);

    // lane0 = 5, lane1 = -96 (0xA0, magnitude bits 5 and 6)
    w = '0; w[0] = 8'd5; w[1] = 8'hA0;
    push_term(1, 0, 16'h0001, 32'h0, 3'd0, 1);
    push_term(0, 0, 16'h0003, 32'h0000_000C, 3'd2, 1);
    push_term(0, 1, 16'h0002, 32'h0, 3'd6, 1);
    send(w, a, 1);
    wait_drain(100);

    w = '0;
    push_term(1, 1, 16'h0000, 32'h0, 3'd0, 0);
    send(w, a, 1);
    wait_drain(100);

    for (int j = 0; j < 16; j++) w[j] = 8'hFF;
    push_term(1, 1, 16'hFFFF, 32'h0, 3'd0, 1);
    send(w, a, 1);
    wait_drain(100);

    w = '0; w[0] = 8'd127;
    for (int k = 0; k < 7; k++) push_term(k == 0, k == 6, 16'h0001, 32'h0, 3'(k), 1);
    send(w, a, 1);
    wait_drain(100);

    w = '0; w[15] = 8'h80;
    push_term(1, 1, 16'h8000, 32'h0, 3'd7, 1);
    send(w, a, 1);
    wait_drain(100);

    // Stall pattern 1,0,0,1 on the 127 group
    w = '0; w[0] = 8'd127;
    for (int k = 0; k < 7; k++) push_term(k == 0, k == 6, 16'h0001, 32'h0, 3'(k), 1);
    rdy_auto = 1'b0; out_ready = 1'b1;
    send(w, a, 1);
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1; rdy_auto = 1'b1;
    wait_drain(100);

    // Back-to-back: second group offered while the first is still running
    w = '0; w[0] = 8'd5; w[1] = 8'hA0;
    w2 = '0; w2[15] = 8'h80;
    push_term(1, 0, 16'h0001, 32'h0, 3'd0, 1);
    push_term(0, 0, 16'h0003, 32'h0000_000C, 3'd2, 1);
    push_term(0, 1, 16'h0002, 32'h0, 3'd6, 1);
    push_term(1, 1, 16'h8000, 32'h0, 3'd7, 1);
    send(w, a, 1);
    send(w2, a, 1);
    wait_drain(100);
    check("b2b_gap", 128'(last_gap), 128'd0);

    // Reset during the second term cycle
    w = '0; w[0] = 8'd127;
    for (int k = 0; k < 7; k++) push_term(k == 0, k == 6, 16'h0001, 32'h0, 3'(k), 1);
    send(w, a, 1);
    @(posedge clk); #1 reset = 1'b0;
    tq.delete(); gq.delete(); acc = 0; ncyc = 0;
    #1 check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 check("mid_rst_hold_valid", out_valid, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    #1 check("rel_in_ready", in_ready, 1'b1);
    check("rel_out_valid", out_valid, 1'b0);
    w = '0; w[0] = 8'd5; w[1] = 8'hA0;
    push_term(1, 0, 16'h0001, 32'h0, 3'd0, 1);
    push_term(0, 0, 16'h0003, 32'h0000_000C, 3'd2, 1);
    push_term(0, 1, 16'h0002, 32'h0, 3'd6, 1);
    send(w, a, 1);
    wait_drain(100);

    // Random groups with random backpressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      for (int j = 0; j < 16; j++) begin
        w[j] = 8'($urandom);
        a[j] = 8'($urandom);
      end
      send(w, a, 0);
    end
    wait_drain(5000);
    rdy_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
